// File: rtl/vga_timing.sv
// Purpose: VGA raster timing generator (pixel/line counters, sync, visible-area and row-phase decodes).
// Latency: counters are registers; every other output is a zero-latency combinational decode of them.
// Backpressure: ena low freezes every register; decoded outputs stay consistent with the held state.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [6:0] vrow,
  output logic [1:0] row_phase,
  output logic [7:0] frame
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 10-bit copies of the timing boundaries so all compares are width-matched.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] hpos_nxt;
  logic [9:0] vpos_nxt;
  logic [1:0] row_phase_nxt;
  logic [7:0] frame_nxt;

  // Next-state arithmetic: line wrap advances vpos, frame wrap advances frame.
  always_comb begin
    h_wrap        = (hpos == H_LAST);
    v_wrap        = (vpos == V_LAST);
    hpos_nxt      = hpos + 10'd1;
    vpos_nxt      = vpos;
    row_phase_nxt = row_phase;
    frame_nxt     = frame;
    if (h_wrap) begin
      hpos_nxt = 10'd0;
      if (v_wrap) begin
        vpos_nxt  = 10'd0;
        frame_nxt = frame + 8'd1;
      end else begin
        vpos_nxt = vpos + 10'd1;
      end
      // row_phase tracks (vpos/4) mod 3 without a divider: step it each time
      // vpos crosses a multiple of 4, and restart it at the top of the frame.
      if (vpos_nxt == 10'd0) begin
        row_phase_nxt = 2'd0;
      end else if (vpos_nxt[1:0] == 2'b00) begin
        row_phase_nxt = (row_phase == 2'd2) ? 2'd0 : row_phase + 2'd1;
      end
    end
  end

  // State registers: synchronous reset wins over ena; ena low holds everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos      <= 10'd0;
      vpos      <= 10'd0;
      row_phase <= 2'd0;
      frame     <= 8'd0;
    end else if (ena) begin
      hpos      <= hpos_nxt;
      vpos      <= vpos_nxt;
      row_phase <= row_phase_nxt;
      frame     <= frame_nxt;
    end
  end

  // Output decodes straight off the registers.
  assign hsync       = !((hpos >= HS_BEG) && (hpos < HS_END));
  assign vsync       = !((vpos >= VS_BEG) && (vpos < VS_END));
  assign display_on  = (hpos < H_VIS) && (vpos < V_VIS);
  assign line_start  = (hpos == 10'd0);
  assign frame_start = (hpos == 10'd0) && (vpos == 10'd0);
  // Only exact vpos/4 below line 512; downstream divide-by-3 relies on this.
  assign vrow        = vpos[8:2];

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance checked against a vector table
// and a per-pixel line sweep, plus a small-timing instance checked every cycle
// against an absolute-time reference model under random ena/reset.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- default-timing instance ----------------
  logic       rst_a, ena_a;
  logic [9:0] a_hpos, a_vpos;
  logic       a_hsync, a_vsync, a_disp, a_ls, a_fs;
  logic [6:0] a_vrow;
  logic [1:0] a_rp;
  logic [7:0] a_frame;

  vga_timing u_dut_a (
    .clk(clk), .rst_n(rst_a), .ena(ena_a),
    .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hsync), .vsync(a_vsync),
    .display_on(a_disp), .line_start(a_ls), .frame_start(a_fs),
    .vrow(a_vrow), .row_phase(a_rp), .frame(a_frame)
  );

  // ---------------- small-timing instance ----------------
  localparam int SH_V = 3,  SH_F = 1, SH_S = 2, SH_B = 2;
  localparam int SV_V = 16, SV_F = 1, SV_S = 2, SV_B = 1;
  localparam int SH_T = SH_V + SH_F + SH_S + SH_B;   // 8
  localparam int SV_T = SV_V + SV_F + SV_S + SV_B;   // 20
  localparam int S_FRAME = SH_T * SV_T;              // 160

  logic       rst_b, ena_b;
  logic [9:0] b_hpos, b_vpos;
  logic       b_hsync, b_vsync, b_disp, b_ls, b_fs;
  logic [6:0] b_vrow;
  logic [1:0] b_rp;
  logic [7:0] b_frame;

  vga_timing #(
    .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b), .ena(ena_b),
    .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
    .display_on(b_disp), .line_start(b_ls), .frame_start(b_fs),
    .vrow(b_vrow), .row_phase(b_rp), .frame(b_frame)
  );

  // ---------------- vector table for the default instance ----------------
  typedef struct {
    logic rst_n;
    logic ena;
    int   ncyc;
    int   hpos;
    int   vpos;
    logic hsync;
    logic vsync;
    logic disp;
    logic ls;
    logic fs;
    int   frame;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vectors();
    logic [47:0] got, exp;
    for (int i = 0; i < 14; i++) begin
      rst_a = vecs[i].rst_n;
      ena_a = vecs[i].ena;
      repeat (vecs[i].ncyc) @(posedge clk);
      #1;
      got = {a_hpos, a_vpos, a_hsync, a_vsync, a_disp, a_ls, a_fs, a_vrow, a_rp, a_frame};
      exp = {10'(vecs[i].hpos), 10'(vecs[i].vpos), vecs[i].hsync, vecs[i].vsync,
             vecs[i].disp, vecs[i].ls, vecs[i].fs, 7'(vecs[i].vpos / 4),
             2'((vecs[i].vpos / 4) % 3), 8'(vecs[i].frame)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL vec%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b vrow=%0d rp=%0d fr=%0d required h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fr=%0d",
                 i, a_hpos, a_vpos, a_hsync, a_vsync, a_disp, a_ls, a_fs, a_vrow, a_rp, a_frame,
                 vecs[i].hpos, vecs[i].vpos, vecs[i].hsync, vecs[i].vsync, vecs[i].disp,
                 vecs[i].ls, vecs[i].fs, vecs[i].frame);
      end
    end
  endtask

  // One full default line: hsync and display_on checked at every column.
  task automatic line_sweep();
    int lows;
    int first_low;
    logic exp_hs, exp_de;
    lows = 0;
    first_low = -1;
    rst_a = 1'b0; ena_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    for (int i = 0; i < 800; i++) begin
      exp_hs = !((i >= 656) && (i < 752));
      exp_de = (i < 640);
      checks++;
      if (a_hpos !== 10'(i) || a_hsync !== exp_hs || a_disp !== exp_de) begin
        failures++;
        $display("FAIL sweep col=%0d got h=%0d hs=%b de=%b required hs=%b de=%b",
                 i, a_hpos, a_hsync, a_disp, exp_hs, exp_de);
      end
      if (a_hsync === 1'b0) begin
        if (first_low < 0) first_low = i;
        lows++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (lows != 96 || first_low != 656) begin
      failures++;
      $display("FAIL hsync_width got lows=%0d first=%0d required lows=96 first=656", lows, first_low);
    end
    checks++;
    if (a_hpos !== 10'd0 || a_vpos !== 10'd1 || a_ls !== 1'b1 || a_fs !== 1'b0) begin
      failures++;
      $display("FAIL line_wrap got h=%0d v=%0d ls=%b fs=%b required h=0 v=1 ls=1 fs=0",
               a_hpos, a_vpos, a_ls, a_fs);
    end
  endtask

  // ---------------- reference model for the small instance ----------------
  // Everything follows from the number of enabled clocks since the last reset.
  int t;

  task automatic check_b(input string tag);
    int h, lines, v, f;
    logic [48:0] got, exp;
    h     = t % SH_T;
    lines = t / SH_T;
    v     = lines % SV_T;
    f     = (lines / SV_T) % 256;
    exp = {10'(h), 10'(v),
           !((h >= SH_V + SH_F) && (h < SH_V + SH_F + SH_S)),
           !((v >= SV_V + SV_F) && (v < SV_V + SV_F + SV_S)),
           (h < SH_V) && (v < SV_V),
           (h == 0), (h == 0) && (v == 0),
           7'((v / 4) % 128), 2'((v / 4) % 3), 8'(f), 1'b0};
    got = {b_hpos, b_vpos, b_hsync, b_vsync, b_disp, b_ls, b_fs, b_vrow, b_rp, b_frame, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b vrow=%0d rp=%0d fr=%0d required h=%0d v=%0d vrow=%0d rp=%0d fr=%0d",
               tag, t, b_hpos, b_vpos, b_hsync, b_vsync, b_disp, b_ls, b_fs, b_vrow, b_rp, b_frame,
               h, v, (v / 4) % 128, (v / 4) % 3, f);
    end
  endtask

  task automatic step_b(input logic rn, input logic en, input string tag);
    rst_b = rn;
    ena_b = en;
    @(posedge clk);
    if (!rn) t = 0;
    else if (en) t++;
    #1;
    check_b(tag);
  endtask

  initial begin
    rst_a = 1'b0; ena_a = 1'b1;
    rst_b = 1'b0; ena_b = 1'b1;
    t = 0;

    //           rst   ena   n    hpos vpos hs    vs    de    ls    fs   fr
    vecs[0]  = '{1'b0, 1'b1, 3,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    vecs[1]  = '{1'b1, 1'b1, 1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b1, 638, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1,   640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b1, 15,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b0, 10,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1,   656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b1, 95,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b1, 1,   752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b1, 47,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b1, 1'b1, 1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[11] = '{1'b1, 1'b1, 300, 300, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[12] = '{1'b0, 1'b0, 1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    vecs[13] = '{1'b1, 1'b0, 5,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};

    run_vectors();
    line_sweep();
    ena_a = 1'b0;

    // Small instance: reset, then random ena with occasional reset pulses.
    repeat (3) step_b(1'b0, 1'b1, "b_reset");
    for (int i = 0; i < 15000; i++) begin
      step_b(($urandom_range(0, 399) != 0), ($urandom_range(0, 3) != 0), "b_rand");
    end

    // 256 full frames from reset, every cycle checked; explicit frame rollover.
    step_b(1'b0, 1'b1, "b_reset2");
    for (int i = 0; i < 256 * S_FRAME - 1; i++) step_b(1'b1, 1'b1, "b_frames");
    checks++;
    if (b_frame !== 8'd255 || b_hpos !== 10'(SH_T - 1) || b_vpos !== 10'(SV_T - 1)) begin
      failures++;
      $display("FAIL frame255 got fr=%0d h=%0d v=%0d required fr=255 h=%0d v=%0d",
               b_frame, b_hpos, b_vpos, SH_T - 1, SV_T - 1);
    end
    step_b(1'b1, 1'b1, "b_wrap");
    checks++;
    if (b_frame !== 8'd0 || b_hpos !== 10'd0 || b_vpos !== 10'd0 || b_fs !== 1'b1) begin
      failures++;
      $display("FAIL frame_wrap got fr=%0d h=%0d v=%0d fs=%b required fr=0 h=0 v=0 fs=1",
               b_frame, b_hpos, b_vpos, b_fs);
    end

    // Mid-frame reset: state must restart from the origin on the next edge.
    for (int i = 0; i < 10 * SH_T + 3; i++) step_b(1'b1, 1'b1, "b_mid");
    checks++;
    if (b_vpos !== 10'd10 || b_hpos !== 10'd3) begin
      failures++;
      $display("FAIL mid_pos got h=%0d v=%0d required h=3 v=10", b_hpos, b_vpos);
    end
    step_b(1'b0, 1'b1, "b_midrst");
    checks++;
    if (b_hpos !== 10'd0 || b_vpos !== 10'd0 || b_rp !== 2'd0 || b_frame !== 8'd0 ||
        b_hsync !== 1'b1 || b_vsync !== 1'b1 || b_disp !== 1'b1 || b_vrow !== 7'd0) begin
      failures++;
      $display("FAIL mid_reset got h=%0d v=%0d rp=%0d fr=%0d hs=%b vs=%b de=%b vrow=%0d required all zero, hs=vs=de=1",
               b_hpos, b_vpos, b_rp, b_frame, b_hsync, b_vsync, b_disp, b_vrow);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
